// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the funct3 load/store select encodings, the FSM state encoding,
// the bus lane count, and small helpers that classify select codes.
package lsu_pkg;

  // Number of byte lanes on the word bus.
  localparam int LANES = 4;

  // funct3 select encodings (loads and stores share the size codes).
  localparam logic [2:0] SEL_B    = 3'b000;
  localparam logic [2:0] SEL_H    = 3'b001;
  localparam logic [2:0] SEL_W    = 3'b010;
  localparam logic [2:0] SEL_BU   = 3'b100;
  localparam logic [2:0] SEL_HU   = 3'b101;
  localparam logic [2:0] SEL_NONE = 3'b111;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT1 = 2'd1;
  localparam logic [1:0] ST_BEAT2 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Stores only support byte, half and word.
  function automatic logic store_sel_legal(input logic [2:0] sel);
    return (sel == SEL_B) || (sel == SEL_H) || (sel == SEL_W);
  endfunction

  // 011 and 110 are the only undefined load codes (111 means "no load").
  function automatic logic load_sel_illegal(input logic [2:0] sel);
    return (sel == 3'b011) || (sel == 3'b110);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for the load/store unit.
// Ports:
//   addr_lo_i   : byte offset within the word (addr[1:0])
//   size_i      : 0 byte, 1 half, 2 word (funct3[1:0])
//   unsigned_i  : zero-extend loads when set (funct3[2])
//   wdata_i     : store data as delivered by the pipeline
//   rd_lo_i     : read data of the first beat
//   rd_hi_i     : read data of the second beat (zero when unsplit)
//   be_lo_o     : lane enables of the first beat
//   be_hi_o     : lane enables of the second beat
//   split_o     : access crosses a word boundary
//   wdata_rot_o : store data rotated into bus lanes
//   rdata_ext_o : assembled and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]         addr_lo_i,
  input  logic [1:0]         size_i,
  input  logic               unsigned_i,
  input  logic [8*LANES-1:0] wdata_i,
  input  logic [8*LANES-1:0] rd_lo_i,
  input  logic [8*LANES-1:0] rd_hi_i,
  output logic [LANES-1:0]   be_lo_o,
  output logic [LANES-1:0]   be_hi_o,
  output logic               split_o,
  output logic [8*LANES-1:0] wdata_rot_o,
  output logic [8*LANES-1:0] rdata_ext_o
);

  logic [2*LANES-1:0]   mask_base;
  logic [2*LANES-1:0]   mask_sh;
  logic [16*LANES-1:0]  rd_cat;
  logic [8*LANES-1:0]   rd_raw;

  // An 8-lane mask spanning two words: the upper half is the second beat,
  // so any bit landing there means the access is split.
  always_comb begin
    case (size_i)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      default: mask_base = 8'h0F;
    endcase
    mask_sh = mask_base << addr_lo_i;
  end

  assign be_lo_o = mask_sh[LANES-1:0];
  assign be_hi_o = mask_sh[2*LANES-1:LANES];
  assign split_o = |mask_sh[2*LANES-1:LANES];
  assign rd_cat  = {rd_hi_i, rd_lo_i};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [1:0] wsrc;
    logic [2:0] rsrc;
    // Store: lane gi takes pipeline byte (gi - offset) mod 4 (rotate left).
    assign wsrc = 2'(gi) - addr_lo_i;
    assign wdata_rot_o[8*gi +: 8] = wdata_i[{wsrc, 3'b000} +: 8];
    // Load: result byte gi comes from lane gi + offset of the two-beat pair.
    assign rsrc = 3'(gi) + {1'b0, addr_lo_i};
    assign rd_raw[8*gi +: 8] = rd_cat[{rsrc, 3'b000} +: 8];
  end

  always_comb begin
    case (size_i)
      2'd0:    rdata_ext_o = unsigned_i ? {24'd0, rd_raw[7:0]}
                                        : {{24{rd_raw[7]}}, rd_raw[7:0]};
      2'd1:    rdata_ext_o = unsigned_i ? {16'd0, rd_raw[15:0]}
                                        : {{16{rd_raw[15]}}, rd_raw[15:0]};
      default: rdata_ext_o = rd_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory op into one or two word-bus
// beats, handling misaligned accesses that cross a word boundary.
// Ports:
//   clk, rst                    : clock, async active-high reset
//   memWrite_M, store_sel_M,
//   load_sel_M, addr_M, wdata_M : pipeline request
//   stall_M, done_M, rdata_M,
//   err_M                       : pipeline response
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata           : registered word-bus request
//   bus_ready, bus_rdata        : bus response
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite_M,
  input  logic [2:0]  store_sel_M,
  input  logic [2:0]  load_sel_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        stall_M,
  output logic        done_M,
  output logic [31:0] rdata_M,
  output logic        err_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  sel_q, sel_d;
  logic        store_q, store_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdat_q, wdat_d;

  logic        is_store, is_load, illegal, legal_op, in_idle;
  logic [2:0]  in_sel;
  logic [1:0]  cur_lo, cur_size;
  logic [31:0] rd_lo, rd_hi;
  logic [3:0]  be_lo, be_hi;
  logic        split;
  logic [31:0] wdata_rot, rdata_ext;

  assign is_store = memWrite_M;
  assign is_load  = !memWrite_M && (load_sel_M != SEL_NONE);
  assign illegal  = is_store ? !store_sel_legal(store_sel_M)
                             : load_sel_illegal(load_sel_M);
  assign legal_op = (is_store || is_load) && !illegal;
  assign in_sel   = is_store ? store_sel_M : load_sel_M;
  assign in_idle  = (state_q == ST_IDLE);

  // In IDLE the aligner sees the incoming op; afterwards the latched one.
  assign cur_lo   = in_idle ? addr_M[1:0] : addr_q[1:0];
  assign cur_size = in_idle ? in_sel[1:0] : sel_q[1:0];
  assign rd_lo    = (state_q == ST_BEAT2) ? lo_q : bus_rdata;
  assign rd_hi    = (state_q == ST_BEAT2) ? bus_rdata : 32'd0;

  lsu_align u_align (
    .addr_lo_i   (cur_lo),
    .size_i      (cur_size),
    .unsigned_i  (sel_q[2]),
    .wdata_i     (wdata_M),
    .rd_lo_i     (rd_lo),
    .rd_hi_i     (rd_hi),
    .be_lo_o     (be_lo),
    .be_hi_o     (be_hi),
    .split_o     (split),
    .wdata_rot_o (wdata_rot),
    .rdata_ext_o (rdata_ext)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    store_d = store_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    baddr_d = baddr_q;
    be_d    = be_q;
    wdat_d  = wdat_q;
    case (state_q)
      ST_IDLE: begin
        if (legal_op) begin
          state_d = ST_BEAT1;
          addr_d  = addr_M;
          sel_d   = in_sel;
          store_d = is_store;
          req_d   = 1'b1;
          we_d    = is_store;
          baddr_d = {addr_M[31:2], 2'b00};
          be_d    = be_lo;
          wdat_d  = wdata_rot;
        end else begin
          err_d = (is_store || is_load) && illegal;
        end
      end
      ST_BEAT1: begin
        if (bus_ready) begin
          lo_d = bus_rdata;
          if (split) begin
            state_d = ST_BEAT2;
            // Word increment wraps naturally at the top of the address space.
            baddr_d = {addr_q[31:2] + 30'd1, 2'b00};
            be_d    = be_hi;
          end else begin
            state_d = ST_DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rdata_d = store_q ? 32'd0 : rdata_ext;
          end
        end
      end
      ST_BEAT2: begin
        if (bus_ready) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          rdata_d = store_q ? 32'd0 : rdata_ext;
        end
      end
      default: state_d = ST_IDLE;  // DONE: pipeline inputs deliberately ignored
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sel_q   <= SEL_NONE;
      store_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      be_q    <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      store_q <= store_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      wdat_q  <= wdat_d;
    end
  end

  // Stall is combinational so the pipeline holds in the acceptance cycle;
  // gated by rst so it is low throughout reset.
  assign stall_M   = !rst && ((in_idle && legal_op) ||
                              (state_q == ST_BEAT1) || (state_q == ST_BEAT2));
  assign done_M    = (state_q == ST_DONE);
  assign rdata_M   = rdata_q;
  assign err_M     = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdat_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have the following ports (name  direction  width  meaning), with one clock, and reset asynchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- memWrite_M  in  1  store request from pipeline.
- store_sel_M  in  3  store funct3: 000 SB, 001 SH, 010 SW, 111 none.
- load_sel_M  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 111 none.
- addr_M  in  32  byte address (ALU result).
- wdata_M  in  32  store data (rs2).
- stall_M  out  1  pipeline hold request.
- done_M  out  1  one-cycle completion pulse.
- rdata_M  out  32  extended load result, valid while done_M=1.
- err_M  out  1  one-cycle pulse on illegal sel code.
- bus_req  out  1  word bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, bits[1:0]=00.
- bus_be  out  4  byte enables, bit i = byte lane i (little-endian).
- bus_wdata  out  32  lane-aligned write data.
- bus_ready  in  1  bus accepts/completes the current beat.
- bus_rdata  in  32  read data, valid when bus_req & bus_ready.

Function
REQ-002 SHALL classify in IDLE as follows:
- store = memWrite_M=1.
- load = memWrite_M=0 & load_sel_M!=111.
- otherwise no-op.
REQ-003 SHALL treat store_sel_M not in {000,001,010} with memWrite_M=1, or load_sel_M in {011,110}, as illegal: err_M=1 next cycle, no bus beat, no stall.
REQ-004 SHALL use FSM states IDLE, BEAT1, BEAT2, DONE.
REQ-005 SHALL transition as follows:
- IDLE->BEAT1 on a legal op.
- BEAT1->BEAT2 on ready when the access is split.
- BEAT1->DONE on ready when it is not split.
- BEAT2->DONE on ready.
- DONE->IDLE unconditionally.
REQ-006 SHALL drive stall_M=1 combinationally in IDLE with a legal op, and in BEAT1/BEAT2; stall_M=0 in DONE.
REQ-007 SHALL ignore pipeline inputs in DONE, so the stalled instruction is not re-accepted.
REQ-008 SHALL register bus outputs.
- bus_req=1 only in BEAT1/BEAT2.
- bus_addr/bus_we/bus_be/bus_wdata stay stable while bus_req=1 & bus_ready=0.
REQ-009 SHALL split an access when it crosses a word boundary: LH/LHU/SH with addr[1:0]=11, or LW/SW with addr[1:0]!=00.
REQ-010 SHALL issue a split access as two beats:
- Beat 1: word at addr&~3, lanes addr[1:0]..3.
- Beat 2: word at (addr&~3)+4, modulo 2^32 (FFFFFFFC wraps to 00000000), remaining lanes starting at lane 0.
REQ-011 SHALL byte-rotate store data left by addr[1:0] lanes; each beat carries the rotated bytes in its enabled lanes.
REQ-012 SHALL assemble load bytes little-endian from the enabled lanes of both beats, then extend to 32 bits:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes through.
REQ-013 SHALL register rdata_M and hold it until the next done_M; rdata_M=0 after stores.
REQ-014 SHALL meet the following latency with bus_ready held at 1, op accepted at cycle T:
- unsplit: BEAT1 at T+1, done_M at T+2.
- split: done_M at T+3.
Each bus_ready=0 cycle adds one cycle.
REQ-015 SHALL pulse done_M for exactly one cycle per legal op, in the DONE state.

Reset
REQ-016 SHALL, while rst=1 (asynchronously):
- force state IDLE.
- drive stall_M, done_M, err_M, bus_req, bus_we to 0.
- drive bus_addr, bus_be, bus_wdata, rdata_M to 0.
REQ-017 SHALL abandon any in-flight beat on reset mid-transaction: bus_req falls immediately, no done_M afterward, and partial load data is discarded.

Structure
REQ-018 SHALL place the load/store sel encodings, the FSM state encoding, and the lane-count constant in shared package lsu_pkg.
REQ-019 SHALL factor lane-enable generation, store rotation, and load extension into one combinational sub-module lsu_align.

Verification
REQ-020 SHALL cover the following directed scenarios:
- SW at 0x100, wdata 0xDEADBEEF, ready=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; done_M at T+2.
- LB at 0x203, bus_rdata 0x80xxxxxx -> be 1000, rdata_M 0xFFFFFF80; same with LBU -> 0x00000080.
- LW at 0x102, beat1 rdata 0x4433xxxx, beat2 rdata 0xxxxx6655 -> beats at 0x100 (be 1100) and 0x104 (be 0011); rdata_M 0x66554433; done_M at T+3.
- SH at 0xFFFFFFFF, wdata 0x0000ABCD -> beat1 addr 0xFFFFFFFC be 1000 lane3=CD; beat2 addr 0x00000000 be 0001 lane0=AB.
- load_sel 011 with memWrite_M=0 -> err_M pulse, stall_M=0, no bus_req; bus_ready=0 for 3 cycles on SW -> beat held stable, done_M at T+5.
- rst asserted in BEAT2 of a split LW -> bus_req=0 same cycle, no done_M, FSM idle after release.
